// File: rtl/simd_inst_receiver_pkg.sv
// Shared types for the SIMD instruction receiver: instruction record and field widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package simd_inst_receiver_pkg;

  // Instruction memory size; pc must be able to encode N_INST itself.
  localparam int N_INST   = 16;
  // Warps per block.
  localparam int MAX_WARP = 32;
  // Offset element width and number of offset dimensions.
  localparam int WBW      = 16;
  localparam int VDIM     = 4;

  localparam int INST_BW  = $clog2(N_INST + 1);
  localparam int WID_BW   = $clog2(MAX_WARP);

  typedef logic [VDIM-1:0][WBW-1:0] ofs_vec_t;

  // One issued instruction as it travels through the buffer and onto the ALU port.
  typedef struct packed {
    logic [INST_BW-1:0] pc;
    logic [WID_BW-1:0]  warpid;
    ofs_vec_t           bofs;
    ofs_vec_t           aofs;
  } simd_inst_t;

  // Pointer width for a buffer of 'depth' entries; a single-entry buffer still
  // needs a one-bit pointer so the declaration stays legal.
  function automatic int ptr_bw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/simd_inst_fifo.sv
// In-order instruction buffer of DEPTH entries with push/pop/count interface.
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: push is ignored when full, pop is ignored when empty; the
//   caller sees fullness through count, which is registered.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   push, push_dat      write one instruction at the tail
//   pop                 retire the head entry
//   head_dat            current head entry (combinational read of storage)
//   count               number of valid entries, 0..DEPTH
module simd_inst_fifo
  import simd_inst_receiver_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_BW = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              push,
  input  simd_inst_t        push_dat,
  input  logic              pop,
  output simd_inst_t        head_dat,
  output logic [CNT_BW-1:0] count
);

  localparam int PTR_BW = ptr_bw(DEPTH);
  localparam logic [CNT_BW-1:0] FULL_CNT = CNT_BW'(DEPTH);
  localparam logic [PTR_BW-1:0] LAST_PTR = PTR_BW'(DEPTH - 1);

  simd_inst_t        mem [DEPTH];
  logic [PTR_BW-1:0] wr_ptr;
  logic [PTR_BW-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Guard both sides locally so the storage can never be corrupted even if
  // a caller misbehaves.
  assign push_ok  = push && (count != FULL_CNT);
  assign pop_ok   = pop && (count != '0);
  assign head_dat = mem[rd_ptr];

  // Storage carries no reset: validity is tracked entirely by count.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap modulo DEPTH, which need not be a power of two.
      if (push_ok) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_BW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_BW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_BW'(1);
        2'b01:   count <= count - CNT_BW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/simd_inst_receiver.sv
// Receives issued SIMD instructions, buffers them in order, dispatches one per
//   cycle into a LATENCY-deep ALU pipe and pulses inst_commit_dval on retire.
// Latency: accept to dispatch 1 cycle (0 with SIMD_RECV_BYPASS_EN and an empty
//   buffer); dispatch to commit LATENCY cycles, plus one per stall cycle.
// Backpressure: inst_ack drops only when the registered count is DEPTH;
//   i_stall freezes dispatch and the pipe but never blocks acceptance.
//
// Optional feature macro: SIMD_RECV_BYPASS_EN (empty-buffer dispatch bypass).
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   inst_rdy / inst_ack           driver presents / receiver accepts
//   i_pc, i_warpid, i_bofs, i_aofs  incoming instruction fields
//   i_stall                       datapath backpressure
//   o_exe_dval, o_exe_*           dispatched instruction to the ALU
//   inst_commit_dval              one instruction retired this cycle
module simd_inst_receiver
  import simd_inst_receiver_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       inst_rdy,
  output logic                       inst_ack,
  input  logic [INST_BW-1:0]         i_pc,
  input  logic [WID_BW-1:0]          i_warpid,
  input  logic [VDIM-1:0][WBW-1:0]   i_bofs,
  input  logic [VDIM-1:0][WBW-1:0]   i_aofs,
  input  logic                       i_stall,
  output logic                       o_exe_dval,
  output logic [INST_BW-1:0]         o_exe_pc,
  output logic [WID_BW-1:0]          o_exe_warpid,
  output logic [VDIM-1:0][WBW-1:0]   o_exe_bofs,
  output logic [VDIM-1:0][WBW-1:0]   o_exe_aofs,
  output logic                       inst_commit_dval
);

  localparam int CNT_BW = $clog2(DEPTH + 1);
  localparam logic [CNT_BW-1:0] FULL_CNT = CNT_BW'(DEPTH);

  simd_inst_t        in_inst;
  simd_inst_t        head_inst;
  simd_inst_t        exe_inst;
  simd_inst_t        exe_out;
  simd_inst_t        last_q;
  logic [CNT_BW-1:0] count;
  logic              buf_empty;
  logic              accept;
  logic              bypass;
  logic              push;
  logic              pop;
  logic              dispatch;
  logic [LATENCY-1:0] pipe_vld;
  logic [LATENCY-1:0] pipe_nxt;

  assign in_inst = {i_pc, i_warpid, i_bofs, i_aofs};

  // Fullness comes from the registered count only, so a pop in the same
  // cycle never makes room for a push, and i_stall plays no part in ack.
  assign buf_empty = (count == '0);
  assign accept    = inst_rdy && (count != FULL_CNT) && !i_rst;
  assign inst_ack  = accept;

`ifdef SIMD_RECV_BYPASS_EN
  // Empty buffer and a free datapath: hand the incoming instruction straight
  // to the ALU instead of parking it for a cycle.
  assign bypass   = accept && buf_empty && !i_stall;
  assign exe_inst = bypass ? in_inst : head_inst;
`else
  assign bypass   = 1'b0;
  assign exe_inst = head_inst;
`endif

  assign push     = accept && !bypass;
  assign pop      = !buf_empty && !i_stall && !i_rst;
  assign dispatch = pop || bypass;

  simd_inst_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .push     (push),
    .push_dat (in_inst),
    .pop      (pop),
    .head_dat (head_inst),
    .count    (count)
  );

  // The ALU port shows the instruction being dispatched, otherwise it keeps
  // presenting the last dispatched one; both read as zero under reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_q <= '0;
    end else if (dispatch) begin
      last_q <= exe_inst;
    end
  end

  assign exe_out      = i_rst ? '0 : (dispatch ? exe_inst : last_q);
  assign o_exe_dval   = dispatch;
  assign o_exe_pc     = exe_out.pc;
  assign o_exe_warpid = exe_out.warpid;
  assign o_exe_bofs   = exe_out.bofs;
  assign o_exe_aofs   = exe_out.aofs;

  // Execution pipe: valid-only shift register. Stage 0 takes the dispatch,
  // the last stage is the retire point. A single-stage pipe has nothing to
  // shift, hence the split.
  generate
    if (LATENCY == 1) begin : g_pipe_one
      assign pipe_nxt = dispatch;
    end else begin : g_pipe_many
      assign pipe_nxt = {pipe_vld[LATENCY-2:0], dispatch};
    end
  endgenerate

  // A stall freezes every stage, so each stall cycle pushes every in-flight
  // commit out by exactly one cycle. Dispatch is already blocked by i_stall,
  // so nothing is dropped at stage 0 while frozen.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pipe_vld <= '0;
    end else if (!i_stall) begin
      pipe_vld <= pipe_nxt;
    end
  end

  assign inst_commit_dval = pipe_vld[LATENCY-1] && !i_stall && !i_rst;

endmodule

// File: tb/tb_simd_inst_receiver.sv
// Self-checking bench for simd_inst_receiver: directed scenarios plus a
// randomized run checked against a queue/countdown reference model.
module tb_simd_inst_receiver;
  import simd_inst_receiver_pkg::*;

  localparam int DEPTH   = 4;
  localparam int LATENCY = 3;
`ifdef SIMD_RECV_BYPASS_EN
  localparam int DISP_LAT = 0;
`else
  localparam int DISP_LAT = 1;
`endif

  logic                     i_clk = 1'b0;
  logic                     i_rst;
  logic                     inst_rdy;
  logic                     inst_ack;
  logic [INST_BW-1:0]       i_pc;
  logic [WID_BW-1:0]        i_warpid;
  logic [VDIM-1:0][WBW-1:0] i_bofs;
  logic [VDIM-1:0][WBW-1:0] i_aofs;
  logic                     i_stall;
  logic                     o_exe_dval;
  logic [INST_BW-1:0]       o_exe_pc;
  logic [WID_BW-1:0]        o_exe_warpid;
  logic [VDIM-1:0][WBW-1:0] o_exe_bofs;
  logic [VDIM-1:0][WBW-1:0] o_exe_aofs;
  logic                     inst_commit_dval;

  always #5 i_clk = ~i_clk;

  simd_inst_receiver #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .inst_rdy         (inst_rdy),
    .inst_ack         (inst_ack),
    .i_pc             (i_pc),
    .i_warpid         (i_warpid),
    .i_bofs           (i_bofs),
    .i_aofs           (i_aofs),
    .i_stall          (i_stall),
    .o_exe_dval       (o_exe_dval),
    .o_exe_pc         (o_exe_pc),
    .o_exe_warpid     (o_exe_warpid),
    .o_exe_bofs       (o_exe_bofs),
    .o_exe_aofs       (o_exe_aofs),
    .inst_commit_dval (inst_commit_dval)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: buffered instructions in order, and for each in-flight
  // instruction the number of unstalled clock edges left before it retires.
  simd_inst_t buf_q[$];
  int         flight_q[$];
  simd_inst_t last_exe;
  simd_inst_t cur_ins;
  logic       cur_bypass;
  logic       exp_ack, exp_dval, exp_commit;
  simd_inst_t exp_exe;

  function automatic simd_inst_t rand_inst();
    simd_inst_t r;
    r.pc     = INST_BW'($urandom_range(0, N_INST));
    r.warpid = WID_BW'($urandom);
    for (int i = 0; i < VDIM; i++) begin
      r.bofs[i] = WBW'($urandom);
      r.aofs[i] = WBW'($urandom);
    end
    return r;
  endfunction

  function automatic simd_inst_t observed();
    return {o_exe_pc, o_exe_warpid, o_exe_bofs, o_exe_aofs};
  endfunction

  // Drive one cycle's inputs (called just after a rising edge), compute the
  // model's expectation, then wait to the falling edge for sampling.
  task automatic apply(input logic rdy, input logic stall, input logic rst,
                       input simd_inst_t ins);
    inst_rdy = rdy;
    i_stall  = stall;
    i_rst    = rst;
    {i_pc, i_warpid, i_bofs, i_aofs} = ins;
    cur_ins    = ins;
    cur_bypass = 1'b0;
    if (rst) begin
      exp_ack = 1'b0; exp_dval = 1'b0; exp_commit = 1'b0; exp_exe = '0;
    end else begin
      exp_ack = rdy && (buf_q.size() != DEPTH);
`ifdef SIMD_RECV_BYPASS_EN
      cur_bypass = exp_ack && (buf_q.size() == 0) && !stall;
`endif
      exp_dval = cur_bypass || ((buf_q.size() != 0) && !stall);
      if (cur_bypass)    exp_exe = ins;
      else if (exp_dval) exp_exe = buf_q[0];
      else               exp_exe = last_exe;
      exp_commit = !stall && (flight_q.size() != 0) && (flight_q[0] == 0);
    end
    @(negedge i_clk);
  endtask

  // Cross the rising edge and move the model forward by one cycle.
  task automatic advance();
    @(posedge i_clk);
    if (i_rst) begin
      buf_q.delete();
      flight_q.delete();
      last_exe = '0;
    end else begin
      if (exp_commit) void'(flight_q.pop_front());
      if (!i_stall) foreach (flight_q[i]) flight_q[i]--;
      if (exp_dval) begin
        if (!cur_bypass) void'(buf_q.pop_front());
        last_exe = exp_exe;
        flight_q.push_back(LATENCY - 1);
      end
      if (exp_ack && !cur_bypass) buf_q.push_back(cur_ins);
    end
    #1;
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b0, 1'b1, rand_inst());
    n_cmp++; if (inst_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got=%b want=0", inst_ack); end
    n_cmp++; if (o_exe_dval !== 1'b0) begin n_fail++; $display("FAIL rst_dval got=%b want=0", o_exe_dval); end
    n_cmp++; if (inst_commit_dval !== 1'b0) begin n_fail++; $display("FAIL rst_commit got=%b want=0", inst_commit_dval); end
    advance();
    apply(1'b0, 1'b0, 1'b0, '0);
    n_cmp++; if (observed() !== '0) begin n_fail++; $display("FAIL rst_exe_data got=%h want=0", observed()); end
    n_cmp++; if (o_exe_dval !== 1'b0) begin n_fail++; $display("FAIL post_rst_dval got=%b want=0", o_exe_dval); end
    advance();
  endtask

  task automatic test_single();
    simd_inst_t s;
    int ack_cyc = -1, disp_cyc = -1, com_cyc = -1, n_com = 0;
    logic [INST_BW-1:0] seen_pc = '0;
    logic [WID_BW-1:0]  seen_wid = '0;
    ofs_vec_t           seen_bofs = '0;
    s = rand_inst();
    s.pc = INST_BW'(5);
    s.warpid = WID_BW'(3);
    for (int i = 0; i < VDIM; i++) s.bofs[i] = WBW'(i + 1);
    for (int k = 0; k < 10; k++) begin
      apply(k == 0, 1'b0, 1'b0, (k == 0) ? s : rand_inst());
      if (inst_ack && ack_cyc < 0) ack_cyc = k;
      if (o_exe_dval && disp_cyc < 0) begin
        disp_cyc = k; seen_pc = o_exe_pc; seen_wid = o_exe_warpid; seen_bofs = o_exe_bofs;
      end
      if (inst_commit_dval) begin n_com++; if (com_cyc < 0) com_cyc = k; end
      advance();
    end
    n_cmp++; if (ack_cyc !== 0) begin n_fail++; $display("FAIL single_ack_cyc got=%0d want=0", ack_cyc); end
    n_cmp++; if (disp_cyc !== DISP_LAT) begin n_fail++; $display("FAIL single_disp_cyc got=%0d want=%0d", disp_cyc, DISP_LAT); end
    n_cmp++; if (seen_pc !== INST_BW'(5)) begin n_fail++; $display("FAIL single_pc got=%0d want=5", seen_pc); end
    n_cmp++; if (seen_wid !== WID_BW'(3)) begin n_fail++; $display("FAIL single_warpid got=%0d want=3", seen_wid); end
    n_cmp++; if (seen_bofs !== s.bofs) begin n_fail++; $display("FAIL single_bofs got=%h want=%h", seen_bofs, s.bofs); end
    n_cmp++; if (com_cyc !== DISP_LAT + LATENCY) begin n_fail++; $display("FAIL single_commit_cyc got=%0d want=%0d", com_cyc, DISP_LAT + LATENCY); end
    n_cmp++; if (n_com !== 1) begin n_fail++; $display("FAIL single_commit_cnt got=%0d want=1", n_com); end
  endtask

  task automatic test_burst();
    int acks = 0, n_com = 0, first_com = -1, last_com = -1, first_disp = -1, last_disp = -1;
    logic [INST_BW-1:0] got[$];
    simd_inst_t s;
    for (int k = 0; k < 16; k++) begin
      s = rand_inst();
      s.pc = INST_BW'(k + 1);
      apply(k < 6, 1'b0, 1'b0, s);
      if (inst_ack) acks++;
      if (o_exe_dval) begin
        got.push_back(o_exe_pc);
        if (first_disp < 0) first_disp = k;
        last_disp = k;
      end
      if (inst_commit_dval) begin n_com++; if (first_com < 0) first_com = k; last_com = k; end
      advance();
    end
    n_cmp++; if (acks !== 6) begin n_fail++; $display("FAIL burst_acks got=%0d want=6", acks); end
    n_cmp++;
    if (got.size() !== 6) begin
      n_fail++; $display("FAIL burst_disp_cnt got=%0d want=6", got.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++; if (got[i] !== INST_BW'(i + 1)) begin n_fail++; $display("FAIL burst_order idx=%0d got=%0d want=%0d", i, got[i], i + 1); end
      end
    end
    n_cmp++; if (last_disp - first_disp !== 5) begin n_fail++; $display("FAIL burst_disp_span got=%0d want=5", last_disp - first_disp); end
    n_cmp++; if (n_com !== 6) begin n_fail++; $display("FAIL burst_commit_cnt got=%0d want=6", n_com); end
    n_cmp++; if (last_com - first_com !== 5) begin n_fail++; $display("FAIL burst_commit_span got=%0d want=5", last_com - first_com); end
    n_cmp++; if (first_com - first_disp !== LATENCY) begin n_fail++; $display("FAIL burst_latency got=%0d want=%0d", first_com - first_disp, LATENCY); end
  endtask

  task automatic test_full_stall();
    int acks = 0, n_com = 0;
    logic ack_at4 = 1'bx;
    for (int k = 0; k < 6; k++) begin
      apply(1'b1, 1'b1, 1'b0, rand_inst());
      if (inst_ack) acks++;
      if (k == 4) ack_at4 = inst_ack;
      if (inst_commit_dval) n_com++;
      advance();
    end
    n_cmp++; if (acks !== 4) begin n_fail++; $display("FAIL full_acks got=%0d want=4", acks); end
    n_cmp++; if (ack_at4 !== 1'b0) begin n_fail++; $display("FAIL full_ack_drop got=%b want=0", ack_at4); end
    // Stall released while full: the pop this cycle must not admit a push.
    apply(1'b1, 1'b0, 1'b0, rand_inst());
    n_cmp++; if (inst_ack !== 1'b0) begin n_fail++; $display("FAIL full_pop_push got=%b want=0", inst_ack); end
    n_cmp++; if (o_exe_dval !== 1'b1) begin n_fail++; $display("FAIL full_pop_dval got=%b want=1", o_exe_dval); end
    if (inst_commit_dval) n_com++;
    advance();
    for (int k = 0; k < DEPTH + LATENCY + 4; k++) begin
      apply(1'b0, 1'b0, 1'b0, rand_inst());
      if (inst_commit_dval) n_com++;
      advance();
    end
    n_cmp++; if (n_com !== 4) begin n_fail++; $display("FAIL full_commit_cnt got=%0d want=4", n_com); end
  endtask

  task automatic test_stall_inflight();
    int com_cyc[$];
    for (int k = 0; k < 14; k++) begin
      apply(k < 2, (k == 3) || (k == 4), 1'b0, rand_inst());
      if (inst_commit_dval) com_cyc.push_back(k);
      advance();
    end
    n_cmp++;
    if (com_cyc.size() !== 2) begin
      n_fail++; $display("FAIL stall_commit_cnt got=%0d want=2", com_cyc.size());
    end else begin
      n_cmp++; if (com_cyc[0] !== DISP_LAT + LATENCY + 2) begin n_fail++; $display("FAIL stall_commit0 got=%0d want=%0d", com_cyc[0], DISP_LAT + LATENCY + 2); end
      n_cmp++; if (com_cyc[1] !== DISP_LAT + LATENCY + 3) begin n_fail++; $display("FAIL stall_commit1 got=%0d want=%0d", com_cyc[1], DISP_LAT + LATENCY + 3); end
    end
  endtask

  task automatic test_reset_midflight();
    int n_com_pre = 0, n_com_post = 0, com_cyc = -1, acks_stalled = 0;
    logic rdy, stall, rst;
    for (int k = 0; k < 26; k++) begin
      rdy   = (k < 2) || (k >= 3 && k <= 6) || (k == 17);
      stall = (k >= 3 && k <= 5);
      rst   = (k == 6);
      apply(rdy, stall, rst, rand_inst());
      if (k >= 3 && k <= 5 && inst_ack) acks_stalled++;
      if (k == 6) begin
        n_cmp++; if (inst_ack !== 1'b0) begin n_fail++; $display("FAIL midrst_ack got=%b want=0", inst_ack); end
        n_cmp++; if (inst_commit_dval !== 1'b0) begin n_fail++; $display("FAIL midrst_commit got=%b want=0", inst_commit_dval); end
      end
      if (k == 7) begin
        n_cmp++; if (o_exe_dval !== 1'b0) begin n_fail++; $display("FAIL midrst_dval got=%b want=0", o_exe_dval); end
        n_cmp++; if (observed() !== '0) begin n_fail++; $display("FAIL midrst_data got=%h want=0", observed()); end
      end
      if (inst_commit_dval) begin
        if (k < 17) n_com_pre++;
        else begin n_com_post++; com_cyc = k; end
      end
      advance();
    end
    n_cmp++; if (acks_stalled !== 3) begin n_fail++; $display("FAIL midrst_acks got=%0d want=3", acks_stalled); end
    n_cmp++; if (n_com_pre !== 0) begin n_fail++; $display("FAIL midrst_stale_commit got=%0d want=0", n_com_pre); end
    n_cmp++; if (n_com_post !== 1) begin n_fail++; $display("FAIL midrst_fresh_cnt got=%0d want=1", n_com_post); end
    n_cmp++; if (com_cyc !== 17 + DISP_LAT + LATENCY) begin n_fail++; $display("FAIL midrst_fresh_cyc got=%0d want=%0d", com_cyc, 17 + DISP_LAT + LATENCY); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      apply($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 25,
            $urandom_range(0, 199) == 0, rand_inst());
      n_cmp++; if (inst_ack !== exp_ack) begin n_fail++; $display("FAIL rnd_ack cyc=%0d got=%b want=%b", k, inst_ack, exp_ack); end
      n_cmp++; if (o_exe_dval !== exp_dval) begin n_fail++; $display("FAIL rnd_dval cyc=%0d got=%b want=%b", k, o_exe_dval, exp_dval); end
      n_cmp++; if (observed() !== exp_exe) begin n_fail++; $display("FAIL rnd_exe cyc=%0d got=%h want=%h", k, observed(), exp_exe); end
      n_cmp++; if (inst_commit_dval !== exp_commit) begin n_fail++; $display("FAIL rnd_commit cyc=%0d got=%b want=%b", k, inst_commit_dval, exp_commit); end
      advance();
    end
  endtask

  initial begin
    inst_rdy = 1'b0;
    i_stall  = 1'b0;
    i_rst    = 1'b1;
    {i_pc, i_warpid, i_bofs, i_aofs} = '0;
    last_exe = '0;
    repeat (2) @(posedge i_clk);
    #1;
    test_reset();
    test_single();
    test_burst();
    test_full_stall();
    test_stall_inflight();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
